// File: rtl/bus_fabric.sv
// Single-host, N-endpoint parallel bus fabric: window decode, one-hot select, registered
// read-data mux, req/ack handshake with access timeout and a saturating error counter.
module bus_fabric #(
    parameter int unsigned                 N_EP       = 2,
    parameter int unsigned                 ADDR_WIDTH = 5,
    parameter int unsigned                 DATA_WIDTH = 4,
    parameter logic [N_EP*ADDR_WIDTH-1:0]  BASE_ADDRS = {5'd16, 5'd0},
    parameter logic [N_EP*ADDR_WIDTH-1:0]  RANGES     = {5'd8, 5'd4},
    parameter int unsigned                 TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         h_req,
    input  logic                         h_r_wn,
    input  logic [ADDR_WIDTH-1:0]        h_addr,
    input  logic [DATA_WIDTH-1:0]        h_wdata,
    output logic                         h_ack,
    output logic [DATA_WIDTH-1:0]        h_rdata,
    output logic                         h_err,
    output logic                         busy,
    output logic [7:0]                   err_cnt,
    output logic [N_EP-1:0]              ep_sel,
    output logic                         ep_r_wn,
    output logic [ADDR_WIDTH-1:0]        ep_addr,
    output logic [DATA_WIDTH-1:0]        ep_wdata,
    input  logic [N_EP*DATA_WIDTH-1:0]   ep_rdata,
    input  logic [N_EP-1:0]              ep_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IDX_W = (N_EP > 1) ? $clog2(N_EP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
    logic [N_EP-1:0]       ep_sel_q, ep_sel_d;
    logic                  ep_r_wn_q, ep_r_wn_d;
    logic [ADDR_WIDTH-1:0] ep_addr_q, ep_addr_d;
    logic [DATA_WIDTH-1:0] ep_wdata_q, ep_wdata_d;
    logic                  h_ack_q, h_ack_d;
    logic [DATA_WIDTH-1:0] h_rdata_q, h_rdata_d;
    logic                  h_err_q, h_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  err_inc;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [ADDR_WIDTH-1:0] dec_off;
    logic [ADDR_WIDTH:0]   win_lo, win_hi;

    // Scan from the top index down so the lowest matching window is the one kept.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_off = '0;
        win_lo  = '0;
        win_hi  = '0;
        for (int i = N_EP - 1; i >= 0; i--) begin
            win_lo = {1'b0, BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]};
            win_hi = win_lo + {1'b0, RANGES[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if (({1'b0, h_addr} >= win_lo) && ({1'b0, h_addr} < win_hi)) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
                dec_off = h_addr - win_lo[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_idx_d  = sel_idx_q;
        ep_sel_d   = ep_sel_q;
        ep_r_wn_d  = ep_r_wn_q;
        ep_addr_d  = ep_addr_q;
        ep_wdata_d = ep_wdata_q;
        h_ack_d    = 1'b0;
        h_rdata_d  = h_rdata_q;
        h_err_d    = h_err_q;
        err_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (h_req) begin
                    ep_r_wn_d  = h_r_wn;
                    ep_wdata_d = h_wdata;
                    if (dec_hit) begin
                        state_d   = ST_ACCESS;
                        ep_sel_d  = N_EP'(1) << dec_idx;
                        ep_addr_d = dec_off;
                        sel_idx_d = dec_idx;
                        cnt_d     = '0;
                    end else begin
                        state_d   = ST_RESP;
                        ep_addr_d = h_addr;
                        h_ack_d   = 1'b1;
                        h_err_d   = 1'b1;
                        h_rdata_d = '0;
                        err_inc   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (ep_ack[sel_idx_q]) begin
                    state_d   = ST_RESP;
                    ep_sel_d  = '0;
                    h_ack_d   = 1'b1;
                    h_err_d   = 1'b0;
                    h_rdata_d = ep_r_wn_q ? ep_rdata[int'(sel_idx_q)*DATA_WIDTH +: DATA_WIDTH]
                                          : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    ep_sel_d  = '0;
                    h_ack_d   = 1'b1;
                    h_err_d   = 1'b1;
                    h_rdata_d = '0;
                    err_inc   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_idx_q  <= '0;
            ep_sel_q   <= '0;
            ep_r_wn_q  <= 1'b0;
            ep_addr_q  <= '0;
            ep_wdata_q <= '0;
            h_ack_q    <= 1'b0;
            h_rdata_q  <= '0;
            h_err_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_idx_q  <= sel_idx_d;
            ep_sel_q   <= ep_sel_d;
            ep_r_wn_q  <= ep_r_wn_d;
            ep_addr_q  <= ep_addr_d;
            ep_wdata_q <= ep_wdata_d;
            h_ack_q    <= h_ack_d;
            h_rdata_q  <= h_rdata_d;
            h_err_q    <= h_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign h_ack    = h_ack_q;
    assign h_rdata  = h_rdata_q;
    assign h_err    = h_err_q;
    assign err_cnt  = err_cnt_q;
    assign ep_sel   = ep_sel_q;
    assign ep_r_wn  = ep_r_wn_q;
    assign ep_addr  = ep_addr_q;
    assign ep_wdata = ep_wdata_q;

endmodule
